// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-bus request/acknowledge channel between the memory stage and data memory
interface mem_access_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage: big-endian loads/stores over a req/ack data bus
module mem_access #(
   parameter logic [7:0] OP_LB  = 8'h20,
   parameter logic [7:0] OP_LBU = 8'h21,
   parameter logic [7:0] OP_LH  = 8'h22,
   parameter logic [7:0] OP_LHU = 8'h23,
   parameter logic [7:0] OP_LW  = 8'h24,
   parameter logic [7:0] OP_SB  = 8'h28,
   parameter logic [7:0] OP_SH  = 8'h29,
   parameter logic [7:0] OP_SW  = 8'h2A
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_we,
   input  logic [4:0]         mem_waddr,
   input  logic [31:0]        mem_wdata,
   input  logic               mem_we_hilo,
   input  logic [31:0]        mem_hi,
   input  logic [31:0]        mem_lo,
   input  logic [7:0]         mem_aluop,
   input  logic [31:0]        mem_mem_addr,
   input  logic [31:0]        mem_opv2,
   output logic               wb_we,
   output logic [4:0]         wb_waddr,
   output logic [31:0]        wb_wdata,
   output logic               wb_we_hilo,
   output logic [31:0]        wb_hi,
   output logic [31:0]        wb_lo,
   output logic               stallreq,
   output logic               exc_misalign,
   mem_access_if.master       bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] rdata_q;
   logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
   logic        misalign, aligned_op;
   logic [3:0]  sel;
   logic [31:0] store_data;
   logic [31:0] load_res;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [1:0]  off;

   assign off = mem_mem_addr[1:0];

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_word   = 1'b0;
      is_signed = 1'b0;
      case (mem_aluop)
         OP_LB:   begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         OP_LBU:  begin is_load  = 1'b1; is_byte = 1'b1; end
         OP_LH:   begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
         OP_LW:   begin is_load  = 1'b1; is_word = 1'b1; end
         OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
         OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
         default: ;
      endcase
   end

   assign misalign   = (is_half & off[0]) | (is_word & (off != 2'b00));
   assign aligned_op = (is_load | is_store) & ~misalign;

   always_comb begin
      sel        = 4'b0000;
      store_data = 32'h0;
      if (is_byte) begin
         sel        = 4'b1000 >> off;
         store_data = {4{mem_opv2[7:0]}};
      end else if (is_half) begin
         sel        = off[1] ? 4'b0011 : 4'b1100;
         store_data = {2{mem_opv2[15:0]}};
      end else if (is_word) begin
         sel        = 4'b1111;
         store_data = mem_opv2;
      end
   end

   // Lane 3 (bits 31:24) holds byte offset 0.
   always_comb begin
      case (off)
         2'd0:    lane_byte = rdata_q[31:24];
         2'd1:    lane_byte = rdata_q[23:16];
         2'd2:    lane_byte = rdata_q[15:8];
         default: lane_byte = rdata_q[7:0];
      endcase
      lane_half = off[1] ? rdata_q[15:0] : rdata_q[31:16];
      if (is_byte)
         load_res = {{24{is_signed & lane_byte[7]}}, lane_byte};
      else if (is_half)
         load_res = {{16{is_signed & lane_half[15]}}, lane_half};
      else
         load_res = rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rdata_q <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state == BUSY && bus.bus_ack)
            rdata_q <= bus.bus_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (aligned_op) state_nxt = BUSY;
         BUSY:    if (bus.bus_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The state register clears asynchronously, so bus_req falls with rst_n.
   always_comb begin
      bus.bus_req   = (state == BUSY);
      bus.bus_we    = 1'b0;
      bus.bus_addr  = 32'h0;
      bus.bus_sel   = 4'b0000;
      bus.bus_wdata = 32'h0;
      if (state == BUSY) begin
         bus.bus_we    = is_store;
         bus.bus_addr  = {mem_mem_addr[31:2], 2'b00};
         bus.bus_sel   = sel;
         bus.bus_wdata = is_store ? store_data : 32'h0;
      end
   end

   always_comb begin
      wb_we        = mem_we;
      wb_waddr     = mem_waddr;
      wb_wdata     = mem_wdata;
      wb_we_hilo   = mem_we_hilo;
      wb_hi        = mem_hi;
      wb_lo        = mem_lo;
      stallreq     = aligned_op && (state != DONE);
      exc_misalign = misalign;
      if (is_store || misalign)
         wb_we = 1'b0;
      if (is_load && !misalign && state == DONE)
         wb_wdata = load_res;
      if (!rst_n) begin
         wb_we        = 1'b0;
         wb_waddr     = 5'd0;
         wb_wdata     = 32'h0;
         wb_we_hilo   = 1'b0;
         wb_hi        = 32'h0;
         wb_lo        = 32'h0;
         stallreq     = 1'b0;
         exc_misalign = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - vector table, random ops and reset corner cases for mem_access
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_we, mem_we_hilo;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_opv2;
   logic [7:0]  mem_aluop;
   logic        wb_we, wb_we_hilo, stallreq, exc_misalign;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata, wb_hi, wb_lo;

   int total = 0;
   int bad   = 0;

   mem_access_if bus_if ();

   mem_access dut (
      .clk(clk), .rst_n(rst_n),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_we_hilo(mem_we_hilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_opv2(mem_opv2),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .wb_we_hilo(wb_we_hilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .stallreq(stallreq), .exc_misalign(exc_misalign),
      .bus(bus_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] opv2;
      logic [31:0] rdata;
      int          delay;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        e_txn;
      logic        e_store;
      logic        e_load;
      logic        e_mis;
      logic [3:0]  e_sel;
      logic [31:0] e_bwdata;
      logic [31:0] e_res;
      logic        e_we;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Hand-computed expectations for the table entries.
   function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] opv2,
                               input logic [31:0] rdata, input int delay, input logic txn, input logic st,
                               input logic ld, input logic mis, input logic [3:0] sel,
                               input logic [31:0] bwd, input logic [31:0] res, input logic ewe);
      vec_t v;
      v.op = op; v.addr = addr; v.opv2 = opv2; v.rdata = rdata; v.delay = delay;
      v.we = 1'b1; v.waddr = 5'd5; v.wdata = 32'h1234;
      v.e_txn = txn; v.e_store = st; v.e_load = ld; v.e_mis = mis;
      v.e_sel = sel; v.e_bwdata = bwd; v.e_res = res; v.e_we = ewe;
      return v;
   endfunction

   // Reference model: treats the bus word as four big-endian bytes and works in plain arithmetic.
   function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] opv2,
                                  input logic [31:0] rdata, input int delay, input logic we,
                                  input logic [4:0] waddr, input logic [31:0] wdata);
      vec_t   v;
      int     sz = 0;
      int     o;
      bit     ld = 0, st = 0, sgn = 0;
      longint x;
      case (op)
         8'h20: begin sz = 1; ld = 1; sgn = 1; end
         8'h21: begin sz = 1; ld = 1; end
         8'h22: begin sz = 2; ld = 1; sgn = 1; end
         8'h23: begin sz = 2; ld = 1; end
         8'h24: begin sz = 4; ld = 1; end
         8'h28: begin sz = 1; st = 1; end
         8'h29: begin sz = 2; st = 1; end
         8'h2A: begin sz = 4; st = 1; end
         default: sz = 0;
      endcase
      o = int'(addr % 4);
      v.op = op; v.addr = addr; v.opv2 = opv2; v.rdata = rdata; v.delay = delay;
      v.we = we; v.waddr = waddr; v.wdata = wdata;
      v.e_mis   = (sz != 0) && ((addr % sz) != 0);
      v.e_txn   = (sz != 0) && !v.e_mis;
      v.e_store = st && v.e_txn;
      v.e_load  = ld && v.e_txn;
      v.e_sel   = 4'b0000;
      if (v.e_txn)
         for (int k = 0; k < sz; k++) v.e_sel[3 - o - k] = 1'b1;
      v.e_bwdata = 32'h0;
      if (v.e_store)
         v.e_bwdata = (sz == 1) ? (opv2 & 32'hFF) * 32'h01010101 :
                      (sz == 2) ? (opv2 & 32'hFFFF) * 32'h00010001 : opv2;
      v.e_res = 32'h0;
      if (v.e_load) begin
         x = (longint'(rdata) >> (8 * (4 - o - sz))) & ((64'd1 << (8 * sz)) - 1);
         if (sgn && x >= (64'd1 << (8 * sz - 1))) x = x - (64'd1 << (8 * sz));
         v.e_res = x[31:0];
      end
      v.e_we = (st || v.e_mis) ? 1'b0 : we;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int  stall = 0, reqs = 0;
      bit  done = 0;
      @(posedge clk);
      #1;
      mem_aluop = v.op; mem_mem_addr = v.addr; mem_opv2 = v.opv2;
      mem_we = v.we; mem_waddr = v.waddr; mem_wdata = v.wdata;
      mem_we_hilo = idx[0]; mem_hi = 32'hA000_0000 + idx; mem_lo = 32'h0B00_0000 + idx;
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      chk("exc_misalign", {31'd0, exc_misalign}, {31'd0, v.e_mis});
      chk("wb_hi", wb_hi, 32'hA000_0000 + idx);
      chk("wb_lo", wb_lo, 32'h0B00_0000 + idx);
      chk("wb_we_hilo", {31'd0, wb_we_hilo}, {31'd0, idx[0]});
      chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, v.waddr});
      if (!v.e_txn) begin
         chk("pass stallreq", {31'd0, stallreq}, 32'd0);
         chk("pass bus_req", {31'd0, bus_if.bus_req}, 32'd0);
         chk("pass bus_sel", {28'd0, bus_if.bus_sel}, 32'd0);
         chk("pass wb_we", {31'd0, wb_we}, {31'd0, v.e_we});
         chk("pass wb_wdata", wb_wdata, v.wdata);
      end else begin
         for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (stallreq) stall++;
            if (bus_if.bus_req) begin
               reqs++;
               chk("bus_addr", bus_if.bus_addr, {v.addr[31:2], 2'b00});
               chk("bus_sel", {28'd0, bus_if.bus_sel}, {28'd0, v.e_sel});
               chk("bus_we", {31'd0, bus_if.bus_we}, {31'd0, v.e_store});
               if (v.e_store) chk("bus_wdata", bus_if.bus_wdata, v.e_bwdata);
            end
            bus_if.bus_ack   = bus_if.bus_req && (reqs == v.delay);
            bus_if.bus_rdata = bus_if.bus_ack ? v.rdata : $urandom;
            if (!stallreq) begin
               done = 1;
               chk("done wb_we", {31'd0, wb_we}, {31'd0, v.e_we});
               chk("done wb_wdata", wb_wdata, v.e_load ? v.e_res : v.wdata);
               chk("done bus_req", {31'd0, bus_if.bus_req}, 32'd0);
            end
         end
         if (!done) chk("txn timeout", 32'd0, 32'd1);
         chk("stall cycles", stall, v.delay + 1);
         chk("req cycles", reqs, v.delay);
         bus_if.bus_ack = 1'b0;
      end
   endtask

   initial begin
      vec_t v;
      logic [7:0] ops [11];
      bit   seen;
      ops = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h28, 8'h29, 8'h2A, 8'h00, 8'h25, 8'h2B};

      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      mem_aluop = 8'h24; mem_mem_addr = 32'h100; mem_opv2 = 32'h0;
      mem_we = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h55; mem_we_hilo = 1'b1;
      mem_hi = 32'h11; mem_lo = 32'h22;
      #12;
      chk("rst stallreq", {31'd0, stallreq}, 32'd0);
      chk("rst bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      chk("rst wb_we", {31'd0, wb_we}, 32'd0);
      chk("rst wb_wdata", wb_wdata, 32'd0);
      chk("rst wb_waddr", {27'd0, wb_waddr}, 32'd0);
      chk("rst wb_hi", wb_hi, 32'd0);
      chk("rst wb_we_hilo", {31'd0, wb_we_hilo}, 32'd0);
      mem_mem_addr = 32'h101;
      #1;
      chk("rst exc_misalign", {31'd0, exc_misalign}, 32'd0);
      mem_aluop = 8'h00;
      @(posedge clk); #1 rst_n = 1'b1;

      vecs.push_back(mk(8'h00, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 1));
      vecs.push_back(mk(8'h20, 32'h103, 32'h0, 32'h000000F0, 1, 1, 0, 1, 0, 4'b0001, 32'h0, 32'hFFFFFFF0, 1));
      vecs.push_back(mk(8'h29, 32'h202, 32'hABCD1234, 32'h0, 1, 1, 1, 0, 0, 4'b0011, 32'h12341234, 32'h0, 0));
      vecs.push_back(mk(8'h24, 32'h300, 32'h0, 32'hDEADBEEF, 5, 1, 0, 1, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 1));
      vecs.push_back(mk(8'h24, 32'h101, 32'h0, 32'h0, 1, 0, 0, 0, 1, 4'b0000, 32'h0, 32'h0, 0));
      vecs.push_back(mk(8'h23, 32'h102, 32'h0, 32'h1234ABCD, 2, 1, 0, 1, 0, 4'b0011, 32'h0, 32'h0000ABCD, 1));
      vecs.push_back(mk(8'h22, 32'h100, 32'h0, 32'h80015555, 1, 1, 0, 1, 0, 4'b1100, 32'h0, 32'hFFFF8001, 1));
      vecs.push_back(mk(8'h21, 32'h101, 32'h0, 32'h00A50000, 3, 1, 0, 1, 0, 4'b0100, 32'h0, 32'h000000A5, 1));
      vecs.push_back(mk(8'h28, 32'h102, 32'h00000077, 32'h0, 1, 1, 1, 0, 0, 4'b0010, 32'h77777777, 32'h0, 0));
      vecs.push_back(mk(8'h29, 32'h203, 32'h1, 32'h0, 1, 0, 0, 0, 1, 4'b0000, 32'h0, 32'h0, 0));
      vecs.push_back(mk(8'h2A, 32'h404, 32'hCAFEF00D, 32'h0, 2, 1, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h0, 0));
      foreach (vecs[i]) run_vec(vecs[i], i);

      for (int i = 0; i < 40; i++) begin
         v = model(ops[$urandom_range(10, 0)], $urandom, $urandom, $urandom,
                   int'($urandom_range(4, 1)), 1'($urandom), 5'($urandom), $urandom);
         run_vec(v, 100 + i);
      end

      // Reset while the bus is busy, then a stray ack afterwards.
      @(posedge clk); #1;
      mem_aluop = 8'h24; mem_mem_addr = 32'h400; mem_we = 1'b1; mem_wdata = 32'h99;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus_if.bus_req) seen = 1;
      end
      chk("rst-mid reached busy", {31'd0, seen}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst-mid bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      chk("rst-mid stallreq", {31'd0, stallreq}, 32'd0);
      chk("rst-mid wb_wdata", wb_wdata, 32'd0);
      mem_aluop = 8'h00;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
      @(negedge clk); bus_if.bus_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("post-rst bus_req", {31'd0, bus_if.bus_req}, 32'd0);
         chk("post-rst stallreq", {31'd0, stallreq}, 32'd0);
         @(negedge clk);
      end
      // A following LBU of offset 0 must see only its own ack data.
      run_vec(model(8'h21, 32'h500, 32'h0, 32'h3C000000, 1, 1'b1, 5'd3, 32'h7), 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

endmodule
